// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction fields into 32-bit words and streams them to IMEM through a small FIFO
// Optional ALUop legality check: define INSTR_ENC_CHECK_EN.
module instr_encoder #(
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [3:0]        MAX_ALUOP  = 4'd9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_imm_sel,
  input  logic [5:0]        i_in_rs,
  input  logic [5:0]        i_in_rd,
  input  logic [3:0]        i_in_aluop,
  input  logic [5:0]        i_in_rt,
  input  logic [14:0]       i_in_imm,
  output logic              o_imem_we,
  input  logic              i_imem_ready,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [15:0]       o_words_written,
  output logic              o_addr_wrap,
  output logic              o_enc_err
);

  localparam int unsigned       PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

`ifdef INSTR_ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W:0]    r_wptr;
  logic [PTR_W:0]    r_rptr;
  logic              r_up;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_words;
  logic              r_wrap;
  logic              r_err;

  logic              w_empty;
  logic              w_full;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_illegal;
  logic              w_push;
  logic              w_pop;
  logic [14:0]       w_low;
  logic [31:0]       w_word;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                      (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_in_ready = r_up && !w_full && !i_clear;
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_illegal  = CHECK_EN && (i_in_aluop > MAX_ALUOP);
  assign w_push     = w_accept && !w_illegal;
  assign w_pop      = !w_empty && i_imem_ready && !i_clear;

  assign w_low  = i_in_imm_sel ? i_in_imm : {i_in_rt, 9'd0};
  assign w_word = {i_in_imm_sel, i_in_rs, i_in_rd, i_in_aluop, w_low};

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= w_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_up    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_words <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_up  <= 1'b1;
      r_err <= w_accept && w_illegal;
      if (i_clear) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_addr <= BASE_ADDR;
        r_wrap <= 1'b0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTR_ONE;
          r_addr <= r_addr + ADDR_ONE;
          if (r_words != 16'hFFFF) begin
            r_words <= r_words + 16'd1;
          end
        end
        r_wrap <= w_pop && (&r_addr);
      end
    end
  end

  assign o_in_ready      = w_in_ready;
  assign o_imem_we       = !w_empty;
  assign o_imem_addr     = r_addr;
  assign o_imem_wdata    = w_empty ? 32'd0 : r_mem[r_rptr[PTR_W-1:0]];
  assign o_words_written = r_words;
  assign o_addr_wrap     = r_wrap;
  assign o_enc_err       = r_err;

endmodule
